// File: rtl/s526w_bist_pkg.sv
// rtl/s526w_bist_pkg.sv - shared states, constants and LFSR/MISR step functions for the s526w BIST controller
package s526w_bist_pkg;

    localparam int RSP_W = 6;

    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
    localparam logic [15:0] DEF_MISR_POLY = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Right-shifting Galois LFSR; callers zero-extend to 32 bits and truncate the result.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v, input logic [31:0] poly);
        return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
    endfunction

    // Left-shifting MISR of width w; bits above w-1 in the result are discarded by the caller.
    function automatic logic [31:0] misr_step(input logic [31:0] v, input logic [31:0] poly,
                                              input logic [RSP_W-1:0] d, input int w);
        logic [31:0] s;
        s = v << 1;
        if (v[w-1]) begin
            s = s ^ poly;
        end
        return s ^ {{(32-RSP_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/s526w_misr.sv
// rtl/s526w_misr.sv - signature register compacting the core's six outputs
module s526w_misr
    import s526w_bist_pkg::*;
#(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = DEF_MISR_POLY
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              clr,
    input  logic              en,
    input  logic [RSP_W-1:0]  d,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] r_sig;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= MISR_W'(misr_step({{(32-MISR_W){1'b0}}, r_sig},
                                       {{(32-MISR_W){1'b0}}, MISR_POLY}, d, MISR_W));
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/s526w_bist_ctrl.sv
// rtl/s526w_bist_ctrl.sv - LFSR stimulus / MISR compaction BIST controller for the s526w core
// Optional SIG_COMPARE_EN: registered signature-vs-GOLDEN_SIG comparison on PASS.
module s526w_bist_ctrl
    import s526w_bist_pkg::*;
#(
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = DEF_LFSR_SEED,
    parameter logic [LFSR_W-1:0] LFSR_POLY   = DEF_LFSR_POLY,
    parameter int                MISR_W      = 16,
    parameter logic [MISR_W-1:0] MISR_POLY   = DEF_MISR_POLY,
    parameter int                INIT_CYCLES = 4,
    parameter int                N_PATTERNS  = 1024,
    parameter logic [MISR_W-1:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              START,
    output logic              CUT_G0,
    output logic              CUT_G1,
    output logic              CUT_G2,
    input  logic [RSP_W-1:0]  CUT_RSP,
    output logic              BUSY,
    output logic              DONE,
    output logic [MISR_W-1:0] SIGNATURE,
    output logic              PASS
);

    localparam int CNT_MAX = (INIT_CYCLES > N_PATTERNS) ? INIT_CYCLES : N_PATTERNS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LFSR_W-1:0] r_lfsr;

    logic w_last;
    logic w_start_ok;
    logic w_drive;
    logic w_misr_clr;
    logic w_misr_en;

    assign w_last     = (r_cnt == CNT_W'(1));
    assign w_start_ok = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_drive    = (r_state == ST_RUN) || (r_state == ST_FLUSH);

    // RUN cycle 0 still sees the post-init response, so it is skipped.
    assign w_misr_clr = w_start_ok;
    assign w_misr_en  = ((r_state == ST_RUN) && (r_cnt != CNT_W'(N_PATTERNS))) ||
                        (r_state == ST_FLUSH);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        r_state <= ST_INIT;
                        r_cnt   <= CNT_W'(INIT_CYCLES);
                        r_lfsr  <= LFSR_SEED;
                    end
                end
                ST_INIT: begin
                    if (w_last) begin
                        r_state <= ST_RUN;
                        r_cnt   <= CNT_W'(N_PATTERNS);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // The final pattern stays on the LFSR so FLUSH can hold it.
                    if (w_last) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_lfsr <= LFSR_W'(lfsr_step({{(32-LFSR_W){1'b0}}, r_lfsr},
                                                    {{(32-LFSR_W){1'b0}}, LFSR_POLY}));
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    s526w_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .clr     (w_misr_clr),
        .en      (w_misr_en),
        .d       (CUT_RSP),
        .sig     (SIGNATURE)
    );

    assign CUT_G0 = (r_state == ST_INIT) || (w_drive && r_lfsr[0]);
    assign CUT_G1 = w_drive && r_lfsr[1];
    assign CUT_G2 = w_drive && r_lfsr[2];
    assign BUSY   = (r_state == ST_INIT) || w_drive;
    assign DONE   = (r_state == ST_DONE);

`ifdef SIG_COMPARE_EN
    logic r_pass;

    // FLUSH always compacts, so the final signature is one step beyond SIGNATURE.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pass <= 1'b0;
        end else if (r_state == ST_FLUSH) begin
            r_pass <= (MISR_W'(misr_step({{(32-MISR_W){1'b0}}, SIGNATURE},
                                         {{(32-MISR_W){1'b0}}, MISR_POLY},
                                         CUT_RSP, MISR_W)) == GOLDEN_SIG);
        end else if (w_start_ok) begin
            r_pass <= 1'b0;
        end
    end

    assign PASS = r_pass;
`else
    logic w_golden_unused;
    assign w_golden_unused = ^GOLDEN_SIG;
    assign PASS            = 1'b0;
`endif

endmodule

// File: tb/tb_s526w_bist_ctrl.sv
// tb/tb_s526w_bist_ctrl.sv - directed self-checking bench for s526w_bist_ctrl
module tb_s526w_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef SIG_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [5:0]  rsp_a = '0, rsp_b = '0, rsp_c = '0;
    logic        g0_a, g1_a, g2_a, busy_a, done_a, pass_a;
    logic        g0_b, g1_b, g2_b, busy_b, done_b, pass_b;
    logic        g0_c, g1_c, g2_c, busy_c, done_c, pass_c;
    logic        g0_d, g1_d, g2_d, busy_d, done_d, pass_d;
    logic [15:0] sig_a, sig_b, sig_c, sig_d;

    int n_checks = 0;
    int n_pass   = 0;

    s526w_bist_ctrl #(.INIT_CYCLES(4), .N_PATTERNS(8)) u_dut_a (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_a), .CUT_G0(g0_a), .CUT_G1(g1_a), .CUT_G2(g2_a),
        .CUT_RSP(rsp_a), .BUSY(busy_a), .DONE(done_a), .SIGNATURE(sig_a), .PASS(pass_a));

    s526w_bist_ctrl #(.N_PATTERNS(2), .GOLDEN_SIG(16'h0003)) u_dut_b (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_b), .CUT_G0(g0_b), .CUT_G1(g1_b), .CUT_G2(g2_b),
        .CUT_RSP(rsp_b), .BUSY(busy_b), .DONE(done_b), .SIGNATURE(sig_b), .PASS(pass_b));

    s526w_bist_ctrl #(.N_PATTERNS(2), .GOLDEN_SIG(16'h0004)) u_dut_d (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_b), .CUT_G0(g0_d), .CUT_G1(g1_d), .CUT_G2(g2_d),
        .CUT_RSP(rsp_b), .BUSY(busy_d), .DONE(done_d), .SIGNATURE(sig_d), .PASS(pass_d));

    s526w_bist_ctrl u_dut_c (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_c), .CUT_G0(g0_c), .CUT_G1(g1_c), .CUT_G2(g2_c),
        .CUT_RSP(rsp_c), .BUSY(busy_c), .DONE(done_c), .SIGNATURE(sig_c), .PASS(pass_c));

    // Stand-in core: outputs are a registered function of the previous cycle's inputs.
    function automatic logic [5:0] core_f(input logic [2:0] p);
        return {p[2] ^ p[1], p[1] & p[0], p[0], ~p[2], p[1] | p[2], p[0] ^ p[2]};
    endfunction

    always @(posedge clk) begin
        rsp_a <= core_f({g2_a, g1_a, g0_a});
        rsp_c <= core_f({g2_c, g1_c, g0_c});
    end

    function automatic logic [15:0] m_lfsr(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] m, input logic [5:0] r);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'hB400 : 16'h0000) ^ {10'b0, r};
    endfunction

    function automatic logic [15:0] exp_sig(input int n);
        logic [15:0] l, m;
        l = 16'hACE1;
        m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            m = m_misr(m, core_f(l[2:0]));
            l = m_lfsr(l);
        end
        return m;
    endfunction

    // Pattern on instance a (INIT=4, N=8) in the cycle after edge k of a run.
    function automatic logic [2:0] exp_pat_a(input int k);
        logic [15:0] l;
        int s;
        if (k < 4) return 3'b001;
        s = (k - 4 > 7) ? 7 : k - 4;
        l = 16'hACE1;
        for (int i = 0; i < s; i++) l = m_lfsr(l);
        return l[2:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_done(input int which, input int bound, output int k);
        logic d;
        k = 0;
        d = 1'b0;
        while (!d && k < bound) begin
            @(negedge clk);
            k++;
            d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end
    endtask

    // Full run on instance a, optionally pulsing START at cycle pulse_at.
    task automatic run_a(input int pulse_at, input string tag);
        int k;
        pulse_start(0);
        chk({tag, "_busy0"}, {31'b0, busy_a}, 1);
        chk({tag, "_pat0"}, {29'b0, g2_a, g1_a, g0_a}, {29'b0, exp_pat_a(0)});
        k = 0;
        while (!done_a && k < 40) begin
            if (k == pulse_at) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            k++;
            if (k <= 12 && !done_a)
                chk($sformatf("%s_pat%0d", tag, k), {28'b0, busy_a, g2_a, g1_a, g0_a},
                    {28'b0, 1'b1, exp_pat_a(k)});
        end
        chk({tag, "_latency"}, k, 13);
        chk({tag, "_sig"}, {16'b0, sig_a}, {16'b0, exp_sig(8)});
    endtask

    initial begin
        int k;
        logic [15:0] ref_c;

        // Reset with arbitrary inputs
        start_a = 1'($urandom);
        rsp_b   = 6'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {26'b0, g2_a, g1_a, g0_a, busy_a, done_a, pass_a}, 0);
        chk("rst_sig_a", {16'b0, sig_a}, 0);
        chk("rst_outs_b", {26'b0, g2_b, g1_b, g0_b, busy_b, done_b, pass_b}, 0);
        chk("rst_sig_b", {16'b0, sig_b}, 0);
        start_a = 1'b0;
        rsp_b   = '0;
        rst_n   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), {27'b0, g2_a, g1_a, g0_a, busy_a, done_a}, 0);
        end

        // Timing and signature, then START mid-RUN ignored
        run_a(-1, "run");
        run_a(6, "midstart");

        // Compaction with a fixed response
        rsp_b = 6'h01;
        pulse_start(1);
        wait_done(1, 30, k);
        chk("cmp1_latency", k, 7);
        chk("cmp1_sig_b", {16'b0, sig_b}, 32'h0003);
        chk("cmp1_sig_d", {16'b0, sig_d}, 32'h0003);
        chk("cmp1_pass_b", {31'b0, pass_b}, {31'b0, CMP});
        chk("cmp1_pass_d", {31'b0, pass_d}, 0);
        rsp_b = 6'h3F;
        repeat (3) @(negedge clk);
        chk("done_frozen", {15'b0, done_b, sig_b}, 32'h0001_0003);
        rsp_b = 6'h00;
        pulse_start(1);
        chk("restart_done_low", {30'b0, busy_b, done_b}, 32'h2);
        chk("restart_pass_clr", {31'b0, pass_b}, 0);
        wait_done(1, 30, k);
        chk("cmp0_latency", k, 7);
        chk("cmp0_sig_b", {16'b0, sig_b}, 0);
        chk("cmp0_pass_b", {31'b0, pass_b}, 0);

        // Reset mid-RUN aborts at once; a fresh run matches an uninterrupted one
        pulse_start(0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outs", {26'b0, g2_a, g1_a, g0_a, busy_a, done_a, pass_a}, 0);
        chk("abort_sig", {16'b0, sig_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", {30'b0, busy_a, done_a}, 0);
        run_a(-1, "rerun");

        // Default configuration with the stand-in core, twice
        ref_c = exp_sig(1024);
        for (int r = 0; r < 2; r++) begin
            pulse_start(2);
            wait_done(2, 1100, k);
            chk($sformatf("full%0d_latency", r), k, 1029);
            chk($sformatf("full%0d_sig", r), {16'b0, sig_c}, {16'b0, ref_c});
            chk($sformatf("full%0d_pass", r), {31'b0, pass_c}, {31'b0, CMP && (ref_c == 16'h0000)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
